sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent switch channels.
REQ-002 Parameter STABLE_CNT, default 1000000: consecutive clk cycles an input must hold a new level before it is accepted (20 ms at 50 MHz).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 sw_raw  input  NUM_CH  raw, bouncy, asynchronous switch levels, e.g. SW[1:0].
REQ-006 sw_db  output  NUM_CH  debounced level per channel; feeds the D input and clk input of the latch/flip-flop stage.
REQ-007 sw_rise  output  NUM_CH  one-cycle pulse when sw_db goes 0->1.
REQ-008 sw_fall  output  NUM_CH  one-cycle pulse when sw_db goes 1->0.

Function
REQ-009 Each sw_raw bit SHALL pass through a two-flop synchronizer; sync output is sync_q.
REQ-010 Per channel: if sync_q equals sw_db, the stability counter SHALL clear to 0.
REQ-011 Per channel: if sync_q differs from sw_db and the counter is below STABLE_CNT-1, the counter SHALL increment by 1.
REQ-012 Per channel: if sync_q differs from sw_db and the counter equals STABLE_CNT-1, sw_db SHALL take sync_q and the counter SHALL clear on that edge.
REQ-013 Latency: a clean input step SHALL appear on sw_db exactly 2+STABLE_CNT rising edges after the first edge that samples the new level.
REQ-014 A disagreement lasting fewer than STABLE_CNT consecutive sync_q cycles SHALL leave sw_db unchanged and restart the count from 0.
REQ-015 sw_rise/sw_fall SHALL be registered, high only in the single cycle following the sw_db update, and never both high on one channel.
REQ-016 Counter width SHALL be $clog2(STABLE_CNT); the counter SHALL never wrap past STABLE_CNT-1.
REQ-017 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be accepted on their own schedule.
REQ-018 STABLE_CNT below 2 SHALL be rejected at elaboration.

Reset
REQ-019 rst_n low SHALL immediately clear synchronizer flops, counters, sw_db, sw_rise and sw_fall to 0, regardless of clk.
REQ-020 Reset asserted mid-count SHALL discard the count; after release, a held-high input SHALL be accepted 2+STABLE_CNT edges later and produce a sw_rise pulse.

Configuration
REQ-021 Macro SW_DEBOUNCE_EDGE_EN defined: sw_rise/sw_fall logic per REQ-007, REQ-008 and REQ-015 is compiled in.
REQ-022 Macro SW_DEBOUNCE_EDGE_EN undefined: sw_rise and sw_fall SHALL be tied to constant 0, no edge registers generated; sw_db behaviour unchanged.

Structure
REQ-023 Package sw_debounce_pkg SHALL hold the default STABLE_CNT constant, the default NUM_CH constant and the simulation constant SIM_STABLE_CNT = 4.
REQ-024 One sub-module debounce_ch (synchronizer, counter, level and edge registers for a single bit) SHALL be instantiated NUM_CH times by a generate loop.

Verification (STABLE_CNT=4, NUM_CH=2, SW_DEBOUNCE_EDGE_EN defined unless stated)
REQ-025 Reset, then hold sw_raw=2'b01 -> sw_db=2'b00 for 5 edges, sw_db=2'b01 on edge 6, with sw_rise=2'b01 for one cycle.
REQ-026 From sw_db=2'b01, toggle sw_raw[0] low for 3 cycles, then restore it -> sw_db stays 2'b01 and no sw_fall pulse.
REQ-027 Bounce sw_raw[1] 0,1,0,1 per cycle, then hold 1 -> sw_db[1] rises exactly 6 edges after the final 0->1 sample, single sw_rise[1] pulse.
REQ-028 Assert rst_n low asynchronously while the channel 0 counter is 2 -> all outputs 0 at once; after release with sw_raw=2'b01 held, sw_db[0] rises 6 edges later.
REQ-029 Drive both channels 1->0 on the same cycle -> sw_db=2'b00 on the same edge with sw_fall=2'b11 for one cycle.
REQ-030 Rerun REQ-025 with SW_DEBOUNCE_EDGE_EN undefined -> identical sw_db timing, sw_rise and sw_fall constantly 0.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the sw_debounce switch debouncer.
// Optional edge pulses are enabled by defining SW_DEBOUNCE_EDGE_EN.
package sw_debounce_pkg;

    localparam int unsigned DEF_NUM_CH     = 2;
    localparam int unsigned DEF_STABLE_CNT = 1000000;
    localparam int unsigned SIM_STABLE_CNT = 4;

    // Per-cycle action taken by a channel's stability counter.
    typedef enum logic [1:0] {
        CntClear,
        CntInc,
        CntAccept
    } cnt_op_e;

    // Clamped so an illegal STABLE_CNT still elaborates far enough to hit the config check.
    function automatic int unsigned cnt_width(input int unsigned stable_cnt);
        return (stable_cnt < 2) ? 1 : $clog2(stable_cnt);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-bit debouncer: two-flop synchronizer, stability counter, level register and,
// when SW_DEBOUNCE_EDGE_EN is defined, registered rise/fall pulses.
module debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW   = cnt_width(STABLE_CNT);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT - 1);

    logic            meta_q, meta_d;
    logic            sync_q, sync_d;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    cnt_op_e         cnt_op;

    always_comb begin
        meta_d = raw_i;
        sync_d = meta_q;
    end

    // >= rather than == so a corrupted count can never wrap past CntMax.
    always_comb begin
        cnt_op = CntClear;
        if (sync_q != db_q) begin
            cnt_op = (cnt_q >= CntMax) ? CntAccept : CntInc;
        end
    end

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        unique case (cnt_op)
            CntInc:    cnt_d = cnt_q + 1'b1;
            CntAccept: db_d  = sync_q;
            default:   cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db_o = db_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses are registered alongside db_q, so they coincide with the first cycle of the new level.
    always_comb begin
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer top: one independent debounce_ch per switch bit.
// Define SW_DEBOUNCE_EDGE_EN to build the sw_rise/sw_fall pulse registers.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sw_raw,
    output logic [NUM_CH-1:0] sw_db,
    output logic [NUM_CH-1:0] sw_rise,
    output logic [NUM_CH-1:0] sw_fall
);

    if (STABLE_CNT < 2) begin : g_cfg_check
        $fatal(1, "sw_debounce: STABLE_CNT must be at least 2");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_i (sw_raw[i]),
            .db_o  (sw_db[i]),
            .rise_o(sw_rise[i]),
            .fall_o(sw_fall[i])
        );
    end

endmodule
